// File: rtl/crc_net_pkg.sv
// crc_net_pkg: state encodings, frame constants and CRC-8 step shared by the receive path
package crc_net_pkg;

    typedef enum logic [2:0] {
        S_HUNT,
        S_HEADER,
        S_DATA,
        S_CRC,
        S_DONE
    } rx_state_t;

    localparam logic [15:0] PREAMBLE_PATTERN = 16'hAAAA;
    localparam logic [7:0]  SFD_PATTERN      = 8'hAB;
    localparam logic [7:0]  CRC8_POLY        = 8'h07;

    localparam int PKT_W  = 136;
    localparam int DATA_W = 128;
    localparam int HDR_W  = 8;

    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic bit_in);
        return {crc[6:0], 1'b0} ^ ((crc[7] ^ bit_in) ? CRC8_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/crc8_serial.sv
// crc8_serial: bit-serial CRC-8 (MSB first, init 0, no reflection, no final XOR)
module crc8_serial
    import crc_net_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       enable,
    input  logic       data_in,
    output logic [7:0] crc_out
);

    logic [7:0] r_crc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_crc <= '0;
        else if (clear)
            r_crc <= '0;
        else if (enable)
            r_crc <= crc8_step(r_crc, data_in);
    end

    assign crc_out = r_crc;

endmodule

// File: rtl/rx_frame_receiver.sv
// rx_frame_receiver: locks onto preamble/SFD, reassembles header + 1..16 data bytes, checks CRC-8
module rx_frame_receiver
    import crc_net_pkg::*;
#(
    parameter int PREAMBLE_TAIL_BITS = 8,
    parameter int CNT_W              = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rx_enable,
    input  logic               rx_line,
    output logic [PKT_W-1:0]   rx_packet,
    output logic               rx_valid,
    output logic               rx_crc_ok,
    output logic               rx_busy,
    output logic [CNT_W-1:0]   frame_cnt,
    output logic [CNT_W-1:0]   crc_err_cnt
);

    localparam int          TAIL_W = PREAMBLE_TAIL_BITS + 8;
    localparam logic [23:0] SYNC   = {PREAMBLE_PATTERN, SFD_PATTERN};
    localparam logic [TAIL_W-1:0] TAIL = SYNC[TAIL_W-1:0];

    rx_state_t            r_state, w_state_nxt;
    logic [7:0]           r_bit_cnt, w_bit_cnt_nxt;
    logic [TAIL_W-2:0]    r_window, w_window_nxt;
    logic [HDR_W-1:0]     r_header, w_header_nxt;
    logic [3:0]           r_len, w_len_nxt;
    logic [DATA_W-1:0]    r_data, w_data_nxt;
    logic [7:0]           r_crc_rx, w_crc_rx_nxt;
    logic [PKT_W-1:0]     r_packet, w_packet_nxt;
    logic                 r_valid, w_valid_nxt;
    logic                 r_crc_ok, w_crc_ok_nxt;
    logic [CNT_W-1:0]     r_frame_cnt, w_frame_cnt_nxt;
    logic [CNT_W-1:0]     r_err_cnt, w_err_cnt_nxt;

    logic                 w_crc_clear, w_crc_en;
    logic [7:0]           w_crc_calc;
    logic [TAIL_W-1:0]    w_win_cat;
    logic [7:0]           w_hdr_shift, w_crc_shift, w_last_data;
    logic [6:0]           w_data_idx;
    logic                 w_crc_match;

    crc8_serial u_crc (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (w_crc_clear),
        .enable  (w_crc_en),
        .data_in (rx_line),
        .crc_out (w_crc_calc)
    );

    // The stored window keeps TAIL_W-1 past bits; with the current bit it forms the full compare window.
    assign w_win_cat   = {r_window, rx_line};
    assign w_hdr_shift = {r_header[6:0], rx_line};
    assign w_crc_shift = {r_crc_rx[6:0], rx_line};
    assign w_last_data = (({4'd0, r_len} + 8'd1) << 3) - 8'd1;
    assign w_data_idx  = 7'(8'd127 - r_bit_cnt);
    assign w_crc_match = r_crc_rx == w_crc_calc;

    always_comb begin
        w_state_nxt     = r_state;
        w_bit_cnt_nxt   = r_bit_cnt + 8'd1;
        w_window_nxt    = r_window;
        w_header_nxt    = r_header;
        w_len_nxt       = r_len;
        w_data_nxt      = r_data;
        w_crc_rx_nxt    = r_crc_rx;
        w_packet_nxt    = r_packet;
        w_valid_nxt     = 1'b0;
        w_crc_ok_nxt    = r_crc_ok;
        w_frame_cnt_nxt = r_frame_cnt;
        w_err_cnt_nxt   = r_err_cnt;
        w_crc_clear     = 1'b0;
        w_crc_en        = 1'b0;
        if (!rx_enable) begin
            w_state_nxt   = S_HUNT;
            w_window_nxt  = '0;
            w_bit_cnt_nxt = '0;
        end else begin
            case (r_state)
                S_HUNT: begin
                    w_window_nxt  = w_win_cat[TAIL_W-2:0];
                    w_bit_cnt_nxt = '0;
                    if (w_win_cat == TAIL) begin
                        w_state_nxt = S_HEADER;
                        w_crc_clear = 1'b1;
                    end
                end
                S_HEADER: begin
                    w_header_nxt = w_hdr_shift;
                    if (r_bit_cnt == 8'd7) begin
                        w_len_nxt     = w_hdr_shift[3:0];
                        w_data_nxt    = '0;
                        w_bit_cnt_nxt = '0;
                        w_state_nxt   = S_DATA;
                    end
                end
                S_DATA: begin
                    w_data_nxt[w_data_idx] = rx_line;
                    w_crc_en               = 1'b1;
                    if (r_bit_cnt == w_last_data) begin
                        w_bit_cnt_nxt = '0;
                        w_state_nxt   = S_CRC;
                    end
                end
                S_CRC: begin
                    w_crc_rx_nxt = w_crc_shift;
                    w_state_nxt  = (r_bit_cnt == 8'd7) ? S_DONE : S_CRC;
                end
                S_DONE: begin
                    w_packet_nxt    = {r_header, r_data};
                    w_valid_nxt     = 1'b1;
                    w_crc_ok_nxt    = w_crc_match;
                    w_frame_cnt_nxt = (&r_frame_cnt) ? r_frame_cnt : r_frame_cnt + CNT_W'(1);
                    w_err_cnt_nxt   = (w_crc_match || (&r_err_cnt)) ? r_err_cnt : r_err_cnt + CNT_W'(1);
                    w_window_nxt    = '0;
                    w_bit_cnt_nxt   = '0;
                    w_state_nxt     = S_HUNT;
                end
                default: begin
                    w_state_nxt   = S_HUNT;
                    w_window_nxt  = '0;
                    w_bit_cnt_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_HUNT;
            r_bit_cnt   <= '0;
            r_window    <= '0;
            r_header    <= '0;
            r_len       <= '0;
            r_data      <= '0;
            r_crc_rx    <= '0;
            r_packet    <= '0;
            r_valid     <= 1'b0;
            r_crc_ok    <= 1'b0;
            r_frame_cnt <= '0;
            r_err_cnt   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_window    <= w_window_nxt;
            r_header    <= w_header_nxt;
            r_len       <= w_len_nxt;
            r_data      <= w_data_nxt;
            r_crc_rx    <= w_crc_rx_nxt;
            r_packet    <= w_packet_nxt;
            r_valid     <= w_valid_nxt;
            r_crc_ok    <= w_crc_ok_nxt;
            r_frame_cnt <= w_frame_cnt_nxt;
            r_err_cnt   <= w_err_cnt_nxt;
        end
    end

    assign rx_packet   = r_packet;
    assign rx_valid    = r_valid;
    assign rx_crc_ok   = r_crc_ok;
    assign rx_busy     = (r_state == S_HEADER) || (r_state == S_DATA) || (r_state == S_CRC);
    assign frame_cnt   = r_frame_cnt;
    assign crc_err_cnt = r_err_cnt;

endmodule

// File: tb/tb_rx_frame_receiver.sv
// tb_rx_frame_receiver: random/directed frames against a byte-level reference model with a scoreboard
module tb_rx_frame_receiver;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rx_enable;
    logic          rx_line;
    logic [135:0]  rx_packet;
    logic          rx_valid;
    logic          rx_crc_ok;
    logic          rx_busy;
    logic [CW-1:0] frame_cnt;
    logic [CW-1:0] crc_err_cnt;

    rx_frame_receiver #(.PREAMBLE_TAIL_BITS(8), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_enable   (rx_enable),
        .rx_line     (rx_line),
        .rx_packet   (rx_packet),
        .rx_valid    (rx_valid),
        .rx_crc_ok   (rx_crc_ok),
        .rx_busy     (rx_busy),
        .frame_cnt   (frame_cnt),
        .crc_err_cnt (crc_err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [135:0] pkt;
        logic         ok;
        int           fc;
        int           ec;
        int           cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   m_fc = 0;
    int   m_ec = 0;
    int   max_cnt = (1 << CW) - 1;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [135:0] act, input logic [135:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endfunction

    function automatic logic [7:0] crc8_ref(input logic [127:0] p, input int nbytes);
        logic [7:0] c = 8'h00;
        for (int i = 0; i < nbytes; i++) begin
            c = c ^ p[127-8*i -: 8];
            for (int k = 0; k < 8; k++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction

    task automatic drive_bit(input logic b);
        @(negedge clk);
        rx_line = b;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_bit(1'b0);
    endtask

    task automatic send_sync();
        logic [23:0] s = 24'hAAAAAB;
        for (int i = 23; i >= 0; i--) drive_bit(s[i]);
    endtask

    // flip < 0 sends the frame intact; otherwise that data bit is inverted after the CRC is computed
    task automatic send_frame(input logic [7:0] hdr, input logic [127:0] pay, input int flip);
        int           nb = int'(hdr[3:0]) + 1;
        logic [127:0] mask;
        logic [127:0] sent;
        logic [7:0]   crc;
        logic         ok;
        mask = ~128'h0 << (128 - 8 * nb);
        sent = pay & mask;
        crc  = crc8_ref(sent, nb);
        if (flip >= 0) sent[127-flip] = ~sent[127-flip];
        send_sync();
        for (int i = 7; i >= 0; i--) drive_bit(hdr[i]);
        for (int i = 0; i < 8 * nb; i++) drive_bit(sent[127-i]);
        for (int i = 7; i >= 0; i--) drive_bit(crc[i]);
        ok   = crc8_ref(sent, nb) == crc;
        m_fc = (m_fc < max_cnt) ? m_fc + 1 : m_fc;
        m_ec = (!ok && m_ec < max_cnt) ? m_ec + 1 : m_ec;
        sb.push_back('{pkt: {hdr, sent}, ok: ok, fc: m_fc, ec: m_ec, cyc: cyc + 2});
    endtask

    task automatic send_random(input logic corrupt);
        logic [7:0]   hdr = 8'($urandom);
        logic [127:0] pay = {$urandom, $urandom, $urandom, $urandom};
        int           nb  = int'(hdr[3:0]) + 1;
        send_frame(hdr, pay, corrupt ? int'($urandom_range(0, 8 * nb - 1)) : -1);
    endtask

    always @(negedge clk) begin
        if (rx_valid) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_valid actual=1 required=0 pkt=%h", rx_packet);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_packet", rx_packet, e.pkt);
                chk("sb_crc_ok", 136'(rx_crc_ok), 136'(e.ok));
                chk("sb_frame_cnt", 136'(frame_cnt), 136'(e.fc));
                chk("sb_crc_err_cnt", 136'(crc_err_cnt), 136'(e.ec));
                chk("sb_latency_cycle", 136'(cyc), 136'(e.cyc));
            end
        end
    end

    initial begin
        logic [15:0] w;
        logic        b;
        rst_n     = 1'b0;
        rx_enable = 1'b1;
        rx_line   = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_packet", rx_packet, 136'h0);
        chk("rst_valid", 136'(rx_valid), 136'h0);
        chk("rst_crc_ok", 136'(rx_crc_ok), 136'h0);
        chk("rst_busy", 136'(rx_busy), 136'h0);
        chk("rst_frame_cnt", 136'(frame_cnt), 136'h0);
        chk("rst_crc_err_cnt", 136'(crc_err_cnt), 136'h0);
        rst_n = 1'b1;
        idle(3);

        send_frame(8'h00, {8'hA5, 120'h0}, -1);
        idle(6);
        chk("len0_packet", rx_packet, {8'h00, 8'hA5, 120'h0});
        chk("len0_crc_ok", 136'(rx_crc_ok), 136'h1);
        chk("len0_frame_cnt", 136'(frame_cnt), 136'h1);

        send_frame(8'h0F, 128'h000102030405060708090A0B0C0D0E0F, -1);
        idle(6);
        chk("len16_data", rx_packet[127:0], 128'h000102030405060708090A0B0C0D0E0F);

        send_frame(8'h00, {8'hA5, 120'h0}, 0);
        idle(6);
        chk("corrupt_data", 136'(rx_packet[127:120]), 136'h25);
        chk("corrupt_crc_ok", 136'(rx_crc_ok), 136'h0);
        chk("corrupt_err_cnt", 136'(crc_err_cnt), 136'h1);

        w = 16'h0;
        for (int i = 0; i < 200; i++) begin
            b = 1'($urandom);
            if ({w[14:0], b} == 16'hAAAB) b = 1'b0;
            w = {w[14:0], b};
            drive_bit(b);
        end
        drive_bit(1'b0);
        send_random(1'b0);
        idle(6);

        send_sync();
        for (int i = 7; i >= 0; i--) drive_bit(1'(8'h01 >> i));
        for (int i = 0; i < 5; i++) drive_bit(1'($urandom));
        chk("abort_busy_in_data", 136'(rx_busy), 136'h1);
        rst_n = 1'b0;
        #1;
        chk("abort_rst_packet", rx_packet, 136'h0);
        chk("abort_rst_busy", 136'(rx_busy), 136'h0);
        chk("abort_rst_frame_cnt", 136'(frame_cnt), 136'h0);
        chk("abort_rst_crc_ok", 136'(rx_crc_ok), 136'h0);
        m_fc = 0;
        m_ec = 0;
        @(negedge clk);
        rst_n   = 1'b1;
        rx_line = 1'b0;
        idle(20);
        send_random(1'b0);
        idle(6);

        send_sync();
        for (int i = 7; i >= 5; i--) drive_bit(1'b0);
        @(negedge clk);
        rx_enable = 1'b0;
        rx_line   = 1'b0;
        @(negedge clk);
        chk("abort_en_busy", 136'(rx_busy), 136'h0);
        rx_enable = 1'b1;
        for (int i = 0; i < 5; i++) drive_bit(1'b0);
        for (int i = 7; i >= 0; i--) drive_bit(1'(8'hA5 >> i));
        for (int i = 7; i >= 0; i--) drive_bit(1'(8'h72 >> i));
        idle(20);
        chk("abort_en_frame_cnt", 136'(frame_cnt), 136'(m_fc));
        send_random(1'b0);
        idle(6);

        send_random(1'b0);
        drive_bit(1'b0);
        send_random(1'b1);
        idle(6);

        for (int i = 0; i < 32; i++) begin
            send_random(i % 2 == 0);
            idle(int'($urandom_range(1, 3)));
        end
        idle(6);
        chk("sat_frame_cnt", 136'(frame_cnt), 136'(max_cnt));
        chk("sat_crc_err_cnt", 136'(crc_err_cnt), 136'(max_cnt));

        idle(20);
        chk("sb_drained", 136'(sb.size()), 136'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rx_frame_receiver.md
# rx_frame_receiver

- Serial frame receiver paired with the network controller's transmit path.
- Samples one bit per clk on `rx_line` and locks onto the preamble/SFD.
- Captures the header and 1–16 data bytes, checks the trailing CRC-8, and presents the reassembled 136-bit packet with a one-cycle valid pulse and a CRC verdict.
- Sits between the physical line and the controller's packet consumer; it also keeps frame/error statistics.

## Interface
- `PREAMBLE_TAIL_BITS`, default 8: alternating preamble bits required immediately before the SFD (1..16).
- `CNT_W`, default 16: width of the statistics counters.
- `clk` in 1: clock; one line bit per rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `rx_enable` in 1: receive enable. Low forces HUNT and discards any frame in progress.
- `rx_line` in 1: serial line, MSB first, idle 0.
- `rx_packet` out 136: `[135:128]` header; `[127:0]` data left-aligned, first bit at `[127]`, unused bits 0.
- `rx_valid` out 1: one-cycle pulse when a complete frame is presented.
- `rx_crc_ok` out 1: valid with `rx_valid`; 1 means the received CRC matches the computed CRC.
- `rx_busy` out 1: high in HEADER, DATA and CRC states.
- `frame_cnt` out `CNT_W`: frames completed, saturating.
- `crc_err_cnt` out `CNT_W`: frames with a CRC mismatch, saturating.

## Operation
- Frame on the line: 16-bit preamble 0xAAAA, SFD 0xAB, header byte, `(header[3:0]+1)*8` data bits, CRC byte. All fields MSB first.
- CRC-8: polynomial x^8+x^2+x+1 (0x07), init 0x00, no reflection, no final XOR. Computed over data bits only, not over preamble, SFD, header or CRC.
- States:
  - HUNT: shift `rx_line` into a 16-bit window. Leave when the low `PREAMBLE_TAIL_BITS+8` bits equal the tail of 0xAAAA followed by 0xAB. On the match edge: clear CRC, clear `bit_cnt`, go to HEADER.
  - HEADER: capture 8 bits into the header register. At `bit_cnt==7`: latch `len = header[3:0]`, zero the data register, go to DATA.
  - DATA: shift each bit into the data register at position `127-bit_cnt` and feed it to the CRC with enable=1. At `bit_cnt==(len+1)*8-1`, go to CRC.
  - CRC: capture 8 bits into the CRC register. At `bit_cnt==7`, go to DONE.
  - DONE: drive `rx_packet`, `rx_valid=1`, and `rx_crc_ok=(rx_crc==crc_calc)`. Increment the counters (no wrap). Clear the window, go to HUNT.
- `bit_cnt` is 8 bits. The length arithmetic is done at 8-bit width, max 127.
- Header bits `[7:4]` are passed through unchanged.
- The SFD match is ignored outside HUNT.

## Timing
- Reset values: `rx_packet=0`, `rx_valid=0`, `rx_crc_ok=0`, `rx_busy=0`, `frame_cnt=0`, `crc_err_cnt=0`, state=HUNT, window=0.
- Latency: `rx_valid` rises exactly 1 cycle after the edge that samples the last CRC bit.
- `rx_packet` and `rx_crc_ok` hold their values until the next DONE.
- Back-to-back frames: HUNT restarts from an empty window in the cycle after DONE. The next frame's bits arriving during DONE are lost, so the next frame needs at least one idle bit of spacing or a preamble longer than `PREAMBLE_TAIL_BITS+1` bits.
- Counter saturation: at all-ones the counters hold, with no wrap.
- `rx_enable` low mid-frame: next cycle state=HUNT, window cleared, no `rx_valid`, counters unchanged.
- `rst_n` asserted mid-frame: all registers return to reset values immediately, with no partial output.
- No backpressure: the consumer must take `rx_packet` before the next DONE.

## Structure
- Shared package `crc_net_pkg` holds:
  - state encodings,
  - `PREAMBLE_PATTERN` (16'hAAAA), `SFD_PATTERN` (8'hAB),
  - the CRC polynomial constant,
  - packet field widths (136/128/8).
- Sub-module: reuse the existing `crc8_serial` (clear, enable, data_in, crc_out) as the only child. The FSM, window, counters and output registers stay in this module.

## Test plan
- Length-0 frame: header 0x00, data 0xA5, CRC 0x72 → `rx_valid` pulse; `rx_packet = {8'h00, 8'hA5, 120'h0}`; `rx_crc_ok=1`; `frame_cnt=1`.
- 16-byte frame: header 0x0F, data 0x00..0x0F → `rx_packet[127:0]` = 0x000102…0F. `rx_crc_ok` must match the model CRC.
- Corruption: same as test 1 but with the first data bit inverted → `rx_crc_ok=0`, `crc_err_cnt=1`. The captured data is 0x25.
- Random noise for 200 cycles containing no SFD, then a valid frame → exactly one `rx_valid`, with correct data.
- Reset and enable aborts:
  - `rst_n` pulsed low during DATA → all outputs 0, no `rx_valid`, and the next clean frame is received correctly.
  - `rx_enable` low during HEADER → same result, with no `rx_valid`.
- Two frames separated by one idle bit → two `rx_valid` pulses with correct packets. Force the counters to all-ones and send a frame → they stay all-ones.
